// File: rtl/nx_node_decoder.sv
// Inbound message decoder: dispatches local messages as single-cycle pulses and buffers
// pass-through messages in a 2-entry bypass FIFO. NX_DECODER_STATS_EN enables message counters.
module nx_node_decoder #(
  parameter int unsigned ADDR_ROW_WIDTH = 4,
  parameter int unsigned ADDR_COL_WIDTH = 4,
  parameter int unsigned COMMAND_WIDTH  = 2,
  parameter int unsigned PAYLOAD_WIDTH  = 21,
  parameter int unsigned INSTR_WIDTH    = 15,
  parameter int unsigned INPUTS         = 8,
  parameter int unsigned OUTPUTS        = 8,
  localparam int unsigned MSG_W    = ADDR_ROW_WIDTH + ADDR_COL_WIDTH + COMMAND_WIDTH +
                                     PAYLOAD_WIDTH,
  localparam int unsigned INPUT_W  = $clog2(INPUTS),
  localparam int unsigned OUTPUT_W = $clog2(OUTPUTS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_ROW_WIDTH-1:0] node_row_i,
  input  logic [ADDR_COL_WIDTH-1:0] node_col_i,
  input  logic [MSG_W-1:0]          msg_data_i,
  input  logic                      msg_valid_i,
  output logic                      msg_ready_o,
  output logic [MSG_W-1:0]          byp_data_o,
  output logic                      byp_valid_o,
  input  logic                      byp_ready_i,
  output logic [INSTR_WIDTH-1:0]    instr_data_o,
  output logic                      instr_valid_o,
  output logic [OUTPUT_W-1:0]       map_idx_o,
  output logic [ADDR_ROW_WIDTH-1:0] map_tgt_row_o,
  output logic [ADDR_COL_WIDTH-1:0] map_tgt_col_o,
  output logic [INPUT_W-1:0]        map_tgt_idx_o,
  output logic                      map_tgt_seq_o,
  output logic                      map_valid_o,
  output logic [INPUT_W-1:0]        signal_index_o,
  output logic                      signal_is_seq_o,
  output logic                      signal_state_o,
  output logic                      signal_valid_o,
  output logic                      err_o,
  output logic [15:0]               stat_local_o,
  output logic [15:0]               stat_bypass_o
);

  localparam int unsigned CMD_LSB = PAYLOAD_WIDTH;
  localparam int unsigned COL_LSB = CMD_LSB + COMMAND_WIDTH;
  localparam int unsigned ROW_LSB = COL_LSB + ADDR_COL_WIDTH;
  // OUTPUT payload bit positions, LSB first: seq, tgt_idx, tgt_col, tgt_row, out_idx
  localparam int unsigned MAP_COL_LSB = INPUT_W + 1;
  localparam int unsigned MAP_ROW_LSB = MAP_COL_LSB + ADDR_COL_WIDTH;
  localparam int unsigned MAP_OUT_LSB = MAP_ROW_LSB + ADDR_ROW_WIDTH;

  localparam logic [COMMAND_WIDTH-1:0] CMD_LOAD = COMMAND_WIDTH'(0);
  localparam logic [COMMAND_WIDTH-1:0] CMD_MAP  = COMMAND_WIDTH'(1);
  localparam logic [COMMAND_WIDTH-1:0] CMD_SIG  = COMMAND_WIDTH'(2);

  logic [MSG_W-1:0]         hold_data_q, hold_data_d;
  logic                     hold_valid_q, hold_valid_d;
  logic [PAYLOAD_WIDTH-1:0] payload;
  logic [COMMAND_WIDTH-1:0] cmd;
  logic                     hold_local, dispatch, accept;
  logic                     is_load, is_map, is_sig, is_ctrl;

  logic [MSG_W-1:0] fifo_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             fifo_full, fifo_empty, push, pop;

  logic unused_hold_bits;
  assign unused_hold_bits = ^hold_data_q;

  assign payload    = hold_data_q[PAYLOAD_WIDTH-1:0];
  assign cmd        = hold_data_q[CMD_LSB +: COMMAND_WIDTH];
  assign hold_local = (hold_data_q[ROW_LSB +: ADDR_ROW_WIDTH] == node_row_i) &&
                      (hold_data_q[COL_LSB +: ADDR_COL_WIDTH] == node_col_i);

  assign fifo_full  = (count_q == 2'd2);
  assign fifo_empty = (count_q == 2'd0);
  assign pop        = !fifo_empty && byp_ready_i;
  // A full FIFO still accepts the hold when it is popped in the same cycle.
  assign push       = hold_valid_q && !hold_local && (!fifo_full || pop);
  assign dispatch   = hold_valid_q && hold_local;

  assign msg_ready_o = !hold_valid_q || hold_local || !fifo_full;
  assign accept      = msg_valid_i && msg_ready_o;

  assign byp_data_o  = fifo_q[rd_ptr_q];
  assign byp_valid_o = !fifo_empty;

  always_comb begin
    is_load = 1'b0;
    is_map  = 1'b0;
    is_sig  = 1'b0;
    is_ctrl = 1'b0;
    if (dispatch) begin
      is_load = (cmd == CMD_LOAD);
      is_map  = (cmd == CMD_MAP);
      is_sig  = (cmd == CMD_SIG);
      is_ctrl = !(is_load || is_map || is_sig);
    end
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (dispatch || push) begin
      hold_valid_d = 1'b0;
    end
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = msg_data_i;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      count_q      <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= hold_data_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      instr_valid_o   <= 1'b0;
      instr_data_o    <= '0;
      map_valid_o     <= 1'b0;
      map_idx_o       <= '0;
      map_tgt_row_o   <= '0;
      map_tgt_col_o   <= '0;
      map_tgt_idx_o   <= '0;
      map_tgt_seq_o   <= 1'b0;
      signal_valid_o  <= 1'b0;
      signal_index_o  <= '0;
      signal_is_seq_o <= 1'b0;
      signal_state_o  <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      instr_valid_o  <= is_load;
      map_valid_o    <= is_map;
      signal_valid_o <= is_sig;
      if (is_ctrl) begin
        err_o <= 1'b1;
      end
      if (is_load) begin
        instr_data_o <= payload[INSTR_WIDTH-1:0];
      end
      if (is_map) begin
        map_tgt_seq_o <= payload[0];
        map_tgt_idx_o <= payload[1 +: INPUT_W];
        map_tgt_col_o <= payload[MAP_COL_LSB +: ADDR_COL_WIDTH];
        map_tgt_row_o <= payload[MAP_ROW_LSB +: ADDR_ROW_WIDTH];
        map_idx_o     <= payload[MAP_OUT_LSB +: OUTPUT_W];
      end
      if (is_sig) begin
        signal_state_o  <= payload[0];
        signal_is_seq_o <= payload[1];
        signal_index_o  <= payload[2 +: INPUT_W];
      end
    end
  end

`ifdef NX_DECODER_STATS_EN
  logic [15:0] stat_local_q, stat_bypass_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stat_local_q  <= 16'd0;
      stat_bypass_q <= 16'd0;
    end else begin
      if (dispatch && (stat_local_q != 16'hFFFF)) begin
        stat_local_q <= stat_local_q + 16'd1;
      end
      if (push && (stat_bypass_q != 16'hFFFF)) begin
        stat_bypass_q <= stat_bypass_q + 16'd1;
      end
    end
  end

  assign stat_local_o  = stat_local_q;
  assign stat_bypass_o = stat_bypass_q;
`else
  assign stat_local_o  = 16'd0;
  assign stat_bypass_o = 16'd0;
`endif

endmodule
